// File: rtl/regfile_wb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : shared register-file constants and write-request type
// Rev 1.0 - initial release
// ============================================================================
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int NUM_REGS   = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_ctrl_if.sv
`default_nettype none
// ============================================================================
// regfile_wb_ctrl_if : write-back requests, register-file port, hazard checks
// Rev 1.0 - initial release
// ============================================================================
interface regfile_wb_ctrl_if #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic                      rf_we;
   logic [ADDR_W-1:0]         rf_waddr;
   logic [DATA_W-1:0]         rf_wdata;
   logic                      issue_valid;
   logic [ADDR_W-1:0]         issue_addr;
   logic [ADDR_W-1:0]         chk_addr1;
   logic [ADDR_W-1:0]         chk_addr2;
   logic                      chk_busy1;
   logic                      chk_busy2;

   modport slave (
      input  req_valid, req_addr, req_data, issue_valid, issue_addr, chk_addr1, chk_addr2,
      output req_ready, rf_we, rf_waddr, rf_wdata, chk_busy1, chk_busy2
   );

   modport master (
      output req_valid, req_addr, req_data, issue_valid, issue_addr, chk_addr1, chk_addr2,
      input  req_ready, rf_we, rf_waddr, rf_wdata, chk_busy1, chk_busy2
   );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : round-robin one-hot grant, searching upward from ptr with wrap
// Rev 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  wire logic [N-1:0]     req,
   input  wire logic [IDX_W-1:0] ptr,
   output logic      [N-1:0]     grant,
   output logic      [IDX_W-1:0] idx
);
   always_comb begin
      int  cand;
      logic found;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int k = 0; k < N; k++) begin
         cand = (int'(ptr) + k) % N;
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = IDX_W'(cand);
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// regfile_wb_ctrl : round-robin write-back onto a single register-file port
//                   with a pending-write scoreboard for RAW hazard detection
// Rev 1.0 - initial release
// ============================================================================
module regfile_wb_ctrl
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = REG_DATA_W,
   parameter int ADDR_W  = REG_ADDR_W
) (
   input  wire logic           clk,
   input  wire logic           reset,
   regfile_wb_ctrl_if.slave    bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int NREGS = 1 << ADDR_W;

   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   w_idx;
   logic [NUM_REQ-1:0] w_grant;
   logic [NUM_REQ-1:0] w_ready;
   logic               w_hs;
   logic [ADDR_W-1:0]  w_addr;
   logic [DATA_W-1:0]  w_data;
   logic               r_we;
   logic [ADDR_W-1:0]  r_waddr;
   logic [DATA_W-1:0]  r_wdata;
   logic [NREGS-1:0]   r_busy;
   logic [NREGS-1:0]   w_busy_nxt;

   rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .req   (bus.req_valid),
      .ptr   (r_ptr),
      .grant (w_grant),
      .idx   (w_idx)
   );

   // No grant while reset is held, so nothing is consumed from the requesters
   assign w_ready       = reset ? '0 : w_grant;
   assign w_hs          = |w_ready;
   assign bus.req_ready = w_ready;
   assign w_addr        = bus.req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
   assign w_data        = bus.req_data[int'(w_idx)*DATA_W +: DATA_W];

   always_comb begin
      w_busy_nxt = r_busy;
      if (w_hs)
         w_busy_nxt[w_addr] = 1'b0;
      if (bus.issue_valid)
         w_busy_nxt[bus.issue_addr] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_ptr   <= '0;
         r_busy  <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_we   <= w_hs && (w_addr != '0);
         if (w_hs) begin
            r_waddr <= w_addr;
            r_wdata <= w_data;
            r_ptr   <= (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
         end
      end
   end

   assign bus.rf_we    = r_we;
   assign bus.rf_waddr = r_waddr;
   assign bus.rf_wdata = r_wdata;

   // The in-flight write still reads stale from the register file this cycle
   assign bus.chk_busy1 = r_busy[bus.chk_addr1] |
                          (r_we && (r_waddr == bus.chk_addr1) && (bus.chk_addr1 != '0));
   assign bus.chk_busy2 = r_busy[bus.chk_addr2] |
                          (r_we && (r_waddr == bus.chk_addr2) && (bus.chk_addr2 != '0));
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// tb_regfile_wb_ctrl : directed + random stimulus against a reference model
// Rev 1.0 - initial release
// ============================================================================
module tb_regfile_wb_ctrl;
   import regfile_pkg::*;

   localparam int N = 2;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   regfile_wb_ctrl_if #(.NUM_REQ(N), .DATA_W(32), .ADDR_W(5)) bus ();

   regfile_wb_ctrl #(.NUM_REQ(N), .DATA_W(32), .ADDR_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model state
   bit      busy_m [NUM_REGS];
   int      ptr_m;
   bit      exp_we;
   wb_req_t last_m;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v);
      for (int k = 0; k < N; k++)
         if (v[(ptr_m + k) % N]) return (ptr_m + k) % N;
      return -1;
   endfunction

   function automatic bit exp_busy(input logic [4:0] a);
      return (a != 0) && (busy_m[a] || (exp_we && last_m.addr == a));
   endfunction

   // Inputs are applied just after a negedge; checks run mid low-phase.
   task automatic run_cycle();
      int         g;
      logic [1:0] er;
      wb_req_t    w;
      #2;
      g  = reset ? -1 : pick(bus.req_valid);
      er = (g < 0) ? 2'b00 : 2'(1 << g);
      check("req_ready", 64'(bus.req_ready), 64'(er));
      check("rf_we", 64'(bus.rf_we), 64'(exp_we));
      check("rf_waddr", 64'(bus.rf_waddr), 64'(last_m.addr));
      check("rf_wdata", 64'(bus.rf_wdata), 64'(last_m.data));
      check("chk_busy1", 64'(bus.chk_busy1), 64'(exp_busy(bus.chk_addr1)));
      check("chk_busy2", 64'(bus.chk_busy2), 64'(exp_busy(bus.chk_addr2)));
      @(posedge clk);
      if (reset) begin
         exp_we = 0;
         last_m = '0;
         ptr_m  = 0;
         foreach (busy_m[i]) busy_m[i] = 0;
      end else begin
         exp_we = 0;
         if (g >= 0) begin
            w.addr = bus.req_addr[g*5 +: 5];
            w.data = bus.req_data[g*32 +: 32];
            last_m = w;
            exp_we = (w.addr != REG_ZERO);
            busy_m[w.addr] = 0;
            ptr_m = (g + 1) % N;
         end
         if (bus.issue_valid && bus.issue_addr != 0)
            busy_m[bus.issue_addr] = 1;
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.req_valid   = '0;
      bus.req_addr    = '0;
      bus.req_data    = '0;
      bus.issue_valid = 1'b0;
      bus.issue_addr  = '0;
      bus.chk_addr1   = '0;
      bus.chk_addr2   = '0;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      exp_we = 0;
      last_m = '0;
      ptr_m  = 0;
      foreach (busy_m[i]) busy_m[i] = 0;
      @(posedge clk);
      @(negedge clk);

      // Reset held with requests and issue pending
      bus.req_valid = 2'b11; bus.req_addr = {5'd4, 5'd3}; bus.issue_valid = 1'b1;
      bus.issue_addr = 5'd3; bus.chk_addr1 = 5'd3; bus.chk_addr2 = 5'd4;
      for (int i = 0; i < 2; i++) begin
         #1 check("rst_ready", 64'(bus.req_ready), 64'd0);
         run_cycle();
      end
      reset = 1'b0;
      idle_inputs();
      bus.chk_addr1 = 5'd3;
      #1 check("rst_busy", 64'(bus.chk_busy1), 64'd0);
      check("rst_we", 64'(bus.rf_we), 64'd0);

      // Round-robin from pointer 0
      bus.req_valid = 2'b11;
      bus.req_addr  = {5'd12, 5'd11};
      bus.req_data  = {32'h2222_2222, 32'h1111_1111};
      for (int i = 0; i < 4; i++) begin
         #1 check("rr_grant", 64'(bus.req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
         run_cycle();
         check("rr_we", 64'(bus.rf_we), 64'd1);
      end
      idle_inputs();
      run_cycle();

      // Single write: pointer is back at 0
      bus.req_valid = 2'b01; bus.req_addr = {5'd0, 5'd5}; bus.req_data = {32'h0, 32'hDEADBEEF};
      #1 check("sw_ready", 64'(bus.req_ready), 64'd1);
      run_cycle();
      idle_inputs();
      check("sw_we", 64'(bus.rf_we), 64'd1);
      check("sw_waddr", 64'(bus.rf_waddr), 64'd5);
      check("sw_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
      run_cycle();
      check("sw_we_off", 64'(bus.rf_we), 64'd0);

      // Write to r0 is accepted and dropped
      bus.req_valid = 2'b10; bus.req_addr = {5'd0, 5'd0}; bus.req_data = {32'h1234, 32'h0};
      bus.issue_valid = 1'b1; bus.issue_addr = 5'd0;
      #1 check("r0_ready", 64'(bus.req_ready), 64'd2);
      run_cycle();
      idle_inputs();
      check("r0_we", 64'(bus.rf_we), 64'd0);
      check("r0_busy", 64'(bus.chk_busy1), 64'd0);
      run_cycle();

      // Scoreboard set, in-flight bypass, then clear
      bus.issue_valid = 1'b1; bus.issue_addr = 5'd7;
      run_cycle();
      idle_inputs(); bus.chk_addr1 = 5'd7;
      #1 check("sb_set", 64'(bus.chk_busy1), 64'd1);
      bus.req_valid = 2'b01; bus.req_addr = {5'd0, 5'd7}; bus.req_data = {32'h0, 32'h7777};
      run_cycle();
      bus.req_valid = 2'b00;
      check("sb_inflight", 64'(bus.chk_busy1), 64'd1);
      run_cycle();
      check("sb_clear", 64'(bus.chk_busy1), 64'd0);

      // Set wins over same-edge clear
      bus.issue_valid = 1'b1; bus.issue_addr = 5'd9; bus.chk_addr2 = 5'd9;
      bus.req_valid = 2'b11; bus.req_addr = {5'd9, 5'd9}; bus.req_data = {32'h99, 32'h98};
      run_cycle();
      idle_inputs(); bus.chk_addr2 = 5'd9;
      run_cycle();
      check("setwin_busy", 64'(bus.chk_busy2), 64'd1);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         reset           = ($urandom_range(0, 60) == 0);
         bus.req_valid   = N'($urandom);
         bus.req_addr    = {5'($urandom_range(0, 12)), 5'($urandom_range(0, 12))};
         bus.req_data    = {32'($urandom), 32'($urandom)};
         bus.issue_valid = ($urandom_range(0, 2) == 0);
         bus.issue_addr  = 5'($urandom_range(0, 12));
         bus.chk_addr1   = 5'($urandom_range(0, 12));
         bus.chk_addr2   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 12));
         run_cycle();
      end
      reset = 1'b0;
      idle_inputs();
      run_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
